// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration stream distributor.
package cfg_pkg;

    // Default widths of the tile configuration bus.
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    // Tile id that marks the end of the bitstream.
    localparam logic [7:0] EOS_ID = 8'hFF;

    // LSB of the address-high field inside the ADDR_HI byte.
    localparam int AH_LSB = 0;

    // Header/data parsing states; DONE is terminal until reset.
    typedef enum logic [2:0] {
        HDR_TILE,
        HDR_AH,
        HDR_AL,
        HDR_LEN,
        DATA,
        DONE
    } cfg_state_e;

endpackage

// File: rtl/cfg_hdr_parser.sv
// Packet header FSM: captures tile id, base address and flags bad ids / end of stream.
module cfg_hdr_parser
    import cfg_pkg::*;
#(
    parameter int NB_TILES = 9,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              accept,
    input  logic              data_last,
    output cfg_state_e        state,
    output logic [7:0]        tile_id,
    output logic              tile_bad,
    output logic [ADDR_W-1:0] base_addr,
    output logic              bad_id,
    output logic              cfg_done
);

    localparam logic [7:0] NB_ID = 8'(NB_TILES);

    logic hdr_tile_acc;

    assign hdr_tile_acc = accept && (state == HDR_TILE);
    assign bad_id       = hdr_tile_acc && (in_data != EOS_ID) && (in_data >= NB_ID);

    // Advance one state per accepted byte; DATA leaves only on its last byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= HDR_TILE;
            tile_id   <= '0;
            tile_bad  <= 1'b0;
            base_addr <= '0;
            cfg_done  <= 1'b0;
        end else if (accept) begin
            case (state)
                HDR_TILE: begin
                    tile_id  <= in_data;
                    tile_bad <= (in_data >= NB_ID);
                    if (in_data == EOS_ID) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                    end else begin
                        state <= HDR_AH;
                    end
                end
                HDR_AH: begin
                    base_addr[ADDR_W-1:8] <= in_data[AH_LSB +: ADDR_W-8];
                    state                 <= HDR_AL;
                end
                HDR_AL: begin
                    base_addr[7:0] <= in_data;
                    state          <= HDR_LEN;
                end
                HDR_LEN: state <= DATA;
                DATA:    if (data_last) state <= HDR_TILE;
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: rtl/cfg_stream_distributor.sv
// Byte-stream configuration front-end driving the shared tile config bus.
module cfg_stream_distributor
    import cfg_pkg::*;
#(
    parameter int NB_TILES = 9,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NB_TILES-1:0] select_tile,
    output logic [ADDR_W-1:0]   address_tile,
    output logic [DATA_W-1:0]   data_tile,
    output logic                cfg_done,
    output logic                cfg_error,
    output logic [15:0]         bytes_written
);

    cfg_state_e        state;
    logic [7:0]        tile_id;
    logic              tile_bad;
    logic [ADDR_W-1:0] base_addr;
    logic              bad_id;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        remaining;
    logic              accept;
    logic              data_acc;
    logic              len_acc;
    logic              eos_acc;

    assign accept   = in_valid && in_ready;
    assign data_acc = accept && (state == DATA);
    assign len_acc  = accept && (state == HDR_LEN);
    assign eos_acc  = accept && (state == HDR_TILE) && (in_data == EOS_ID);

    cfg_hdr_parser #(
        .NB_TILES (NB_TILES),
        .ADDR_W   (ADDR_W)
    ) u_hdr (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .accept    (accept),
        .data_last (remaining == 8'd0),
        .state     (state),
        .tile_id   (tile_id),
        .tile_bad  (tile_bad),
        .base_addr (base_addr),
        .bad_id    (bad_id),
        .cfg_done  (cfg_done)
    );

    // Data-phase address and remaining-byte counters, seeded by the LEN byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (len_acc) begin
            cur_addr  <= base_addr;
            remaining <= in_data;
        end else if (data_acc) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - 8'd1;
        end
    end

    // Registered tile bus: one-cycle strobe per delivered byte, sticky error, write count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_ready      <= 1'b0;
            select_tile   <= '0;
            address_tile  <= '0;
            data_tile     <= '0;
            cfg_error     <= 1'b0;
            bytes_written <= '0;
        end else begin
            in_ready    <= (state != DONE) && !eos_acc;
            select_tile <= '0;
            if (bad_id) cfg_error <= 1'b1;
            if (data_acc && !tile_bad) begin
                select_tile  <= NB_TILES'(1) << tile_id;
                address_tile <= cur_addr;
                data_tile    <= in_data;
                if (bytes_written != 16'hFFFF) bytes_written <= bytes_written + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cfg_stream_distributor.sv
// Directed bench: table of per-cycle vectors plus hand sequences for long/reset cases.
module tb_cfg_stream_distributor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  select_tile;
    logic [9:0]  address_tile;
    logic [7:0]  data_tile;
    logic        cfg_done;
    logic        cfg_error;
    logic [15:0] bytes_written;

    int tests = 0;
    int fails = 0;

    cfg_stream_distributor #(.NB_TILES(9), .ADDR_W(10), .DATA_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .select_tile   (select_tile),
        .address_tile  (address_tile),
        .data_tile     (data_tile),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error),
        .bytes_written (bytes_written)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        vld;
        logic [7:0]  din;
        logic [8:0]  sel;
        logic [9:0]  addr;
        logic [7:0]  dat;
        logic        rdy;
        logic        done;
        logic        err;
        logic [15:0] bw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic vld, logic [7:0] din, logic [8:0] sel, logic [9:0] addr,
                               logic [7:0] dat, logic rdy, logic done, logic err, logic [15:0] bw);
        vec_t r;
        r.vld = vld; r.din = din; r.sel = sel; r.addr = addr; r.dat = dat;
        r.rdy = rdy; r.done = done; r.err = err; r.bw = bw;
        return r;
    endfunction

    task automatic check_out(string name, logic [8:0] sel, logic [9:0] addr, logic [7:0] dat,
                             logic rdy, logic done, logic err, logic [15:0] bw);
        tests++;
        if (select_tile !== sel || address_tile !== addr || data_tile !== dat ||
            in_ready !== rdy || cfg_done !== done || cfg_error !== err || bytes_written !== bw) begin
            fails++;
            $display("FAIL %s: got sel=%h addr=%h dat=%h rdy=%b done=%b err=%b bw=%0d, want sel=%h addr=%h dat=%h rdy=%b done=%b err=%b bw=%0d",
                     name, select_tile, address_tile, data_tile, in_ready, cfg_done, cfg_error,
                     bytes_written, sel, addr, dat, rdy, done, err, bw);
        end
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(logic vld, logic [7:0] din);
        in_valid = vld;
        in_data  = din;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 8'h00);
    endtask

    logic [9:0]  ea;
    logic [7:0]  ed;
    logic [15:0] eb;

    initial begin
        // Packet to tile 3 with a mid-data gap.
        tbl.push_back(v(1, 8'h03, 9'h000, 10'h000, 8'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h01, 9'h000, 10'h000, 8'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h2C, 9'h000, 10'h000, 8'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h02, 9'h000, 10'h000, 8'h00, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'hAA, 9'h008, 10'h12C, 8'hAA, 1, 0, 0, 1));
        tbl.push_back(v(0, 8'h00, 9'h000, 10'h12C, 8'hAA, 1, 0, 0, 1));
        tbl.push_back(v(1, 8'hBB, 9'h008, 10'h12D, 8'hBB, 1, 0, 0, 2));
        tbl.push_back(v(1, 8'hCC, 9'h008, 10'h12E, 8'hCC, 1, 0, 0, 3));
        // Back-to-back packet to tile 0 wrapping the address, with a header gap.
        tbl.push_back(v(1, 8'h00, 9'h000, 10'h12E, 8'hCC, 1, 0, 0, 3));
        tbl.push_back(v(1, 8'h03, 9'h000, 10'h12E, 8'hCC, 1, 0, 0, 3));
        tbl.push_back(v(0, 8'h00, 9'h000, 10'h12E, 8'hCC, 1, 0, 0, 3));
        tbl.push_back(v(1, 8'hFE, 9'h000, 10'h12E, 8'hCC, 1, 0, 0, 3));
        tbl.push_back(v(1, 8'h03, 9'h000, 10'h12E, 8'hCC, 1, 0, 0, 3));
        tbl.push_back(v(1, 8'h11, 9'h001, 10'h3FE, 8'h11, 1, 0, 0, 4));
        tbl.push_back(v(1, 8'h22, 9'h001, 10'h3FF, 8'h22, 1, 0, 0, 5));
        tbl.push_back(v(1, 8'h33, 9'h001, 10'h000, 8'h33, 1, 0, 0, 6));
        tbl.push_back(v(1, 8'h44, 9'h001, 10'h001, 8'h44, 1, 0, 0, 7));
        // Bad tile id 0x0A: consumed silently, error goes sticky.
        tbl.push_back(v(1, 8'h0A, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h00, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h00, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h01, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h55, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h66, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        // Following good packet: tile 1, addr 5.
        tbl.push_back(v(1, 8'h01, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h00, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h05, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h00, 9'h000, 10'h001, 8'h44, 1, 0, 1, 7));
        tbl.push_back(v(1, 8'h77, 9'h002, 10'h005, 8'h77, 1, 0, 1, 8));
        // End of stream, then ignored bytes.
        tbl.push_back(v(1, 8'hFF, 9'h000, 10'h005, 8'h77, 0, 1, 1, 8));
        tbl.push_back(v(1, 8'h03, 9'h000, 10'h005, 8'h77, 0, 1, 1, 8));
        tbl.push_back(v(1, 8'hAA, 9'h000, 10'h005, 8'h77, 0, 1, 1, 8));

        // Reset values while reset is held.
        #1;
        check_out("reset_vals", 9'h000, 10'h000, 8'h00, 0, 0, 0, 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 8'h00);
        check_out("ready_after_reset", 9'h000, 10'h000, 8'h00, 1, 0, 0, 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].din);
            check_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].addr, tbl[i].dat,
                      tbl[i].rdy, tbl[i].done, tbl[i].err, tbl[i].bw);
        end

        // Max-length packet: tile 2, base 0x180, LEN=FF, random valid gaps.
        do_reset();
        check_out("ready_after_reset2", 9'h000, 10'h000, 8'h00, 1, 0, 0, 16'd0);
        step(1, 8'h02); step(1, 8'h01); step(1, 8'h80); step(1, 8'hFF);
        check_out("maxlen_hdr", 9'h000, 10'h000, 8'h00, 1, 0, 0, 16'd0);
        ea = 10'h000; ed = 8'h00; eb = 16'd0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 8'h5C);
                check_out($sformatf("maxlen_gap%0d", i), 9'h000, ea, ed, 1, 0, 0, eb);
            end
            step(1'b1, 8'(i));
            ea = 10'h180 + 10'(i);
            ed = 8'(i);
            eb = eb + 16'd1;
            check_out($sformatf("maxlen_byte%0d", i), 9'h004, ea, ed, 1, 0, 0, eb);
        end
        // FSM must be back at HDR_TILE: next packet parses directly.
        step(1, 8'h05); step(1, 8'h00); step(1, 8'h07); step(1, 8'h00);
        check_out("after_max_hdr", 9'h000, ea, ed, 1, 0, 0, 16'd256);
        step(1, 8'h5A);
        check_out("after_max_data", 9'h020, 10'h007, 8'h5A, 1, 0, 0, 16'd257);

        // Reset mid-data after 2 of 4 bytes.
        step(1, 8'h04); step(1, 8'h00); step(1, 8'h10); step(1, 8'h03);
        step(1, 8'hD1);
        check_out("mid_d1", 9'h010, 10'h010, 8'hD1, 1, 0, 0, 16'd258);
        step(1, 8'hD2);
        check_out("mid_d2", 9'h010, 10'h011, 8'hD2, 1, 0, 0, 16'd259);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", 9'h000, 10'h000, 8'h00, 0, 0, 0, 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 8'h00);
        check_out("ready_after_midreset", 9'h000, 10'h000, 8'h00, 1, 0, 0, 16'd0);
        step(1, 8'h06); step(1, 8'h00); step(1, 8'h20); step(1, 8'h00);
        check_out("fresh_hdr", 9'h000, 10'h000, 8'h00, 1, 0, 0, 16'd0);
        step(1, 8'hE7);
        check_out("fresh_data", 9'h040, 10'h020, 8'hE7, 1, 0, 0, 16'd1);
        step(0, 8'h00);
        check_out("fresh_idle", 9'h000, 10'h020, 8'hE7, 1, 0, 0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
